nibble_serial_adder_ctrl: RTL and testbench

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 18 +
 rtl/nibble_serial_adder_ctrl_nibble_adder.sv | 55 +++++
 rtl/nibble_serial_adder_ctrl.sv | 168 ++++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
// Shared definitions for the nibble-serial adder controller:
//   - NIBBLE_W   : width of one processed slice (one nibble)
//   - state_e    : controller state encoding (IDLE / RUN / DONE)
// No ports (package).
// ---------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// ---------------------------------------------------------------------------
// full_adder / nibble_adder
// Purely combinational 4-bit ripple adder built from one-bit full adders.
// Used once by the controller; the carry between nibbles is kept outside
// in a register, so this block only ripples within a single nibble.
// full_adder ports:
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
// nibble_adder ports:
//   A[3:0], B[3:0] : nibble operands (B already inverted for subtract)
//   Cin            : carry-in from the carry register
//   S[3:0]         : nibble sum
//   Cout           : carry out of bit 3
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module nibble_adder
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] S,
  output logic                Cout
);

  // carry_s[i] is the carry into bit i; carry_s[NIBBLE_W] leaves the nibble
  logic [NIBBLE_W:0] carry_s;

  assign carry_s[0] = Cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry_s[i]),
      .s  (S[i]),
      .co (carry_s[i+1])
    );
  end

  assign Cout = carry_s[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Adds or subtracts two W-bit operands one nibble per clock through a single
// 4-bit adder. An accepted Start latches the operands; RUN processes nibble
// 0..NIBBLES-1 (LSB first); DONE presents a one-cycle result pulse.
// Ports:
//   Clock       : rising-edge clock
//   Reset       : asynchronous, active-high reset
//   Start       : operation request, only sampled in IDLE
//   Sub         : 0 = A+B+Cin, 1 = A-B-Cin
//   A, B        : W-bit operands
//   Cin         : carry-in (borrow-in when Sub=1)
//   Busy        : high during each RUN cycle
//   Done        : one-cycle result-valid pulse (DONE state)
//   Sum         : result register, filled LSB nibble first
//   Cout        : final raw carry (in subtract, 1 means no borrow)
//   Ovf         : signed overflow of the full-width result
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Sub,
  input  logic [NIBBLE_W*NIBBLES-1:0] A,
  input  logic [NIBBLE_W*NIBBLES-1:0] B,
  input  logic                       Cin,
  output logic                       Busy,
  output logic                       Done,
  output logic [NIBBLE_W*NIBBLES-1:0] Sum,
  output logic                       Cout,
  output logic                       Ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Bit offset of nibble k (k * 4, expressed as a shift by two)
  logic [KW+1:0]          base_s;
  logic [NIBBLE_W-1:0]    add_a_s;
  logic [NIBBLE_W-1:0]    add_b_s;
  logic [NIBBLE_W-1:0]    add_s_s;
  logic                   add_co_s;
  logic                   b_eff_msb_s;

  assign base_s      = {k_q, 2'b00};
  assign add_a_s     = a_q[base_s +: NIBBLE_W];
  // Subtract uses the one's complement of B; the +1 comes from the carry register
  assign add_b_s     = b_q[base_s +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
  assign b_eff_msb_s = b_q[W-1] ^ sub_q;

  nibble_adder u_nibble_adder (
    .A    (add_a_s),
    .B    (add_b_s),
    .Cin  (carry_q),
    .S    (add_s_s),
    .Cout (add_co_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE controller
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          sub_d   = Sub;
          // Borrow-in becomes the inverted carry-in of a two's complement add
          carry_d = Cin ^ Sub;
          sum_d   = '0;
          k_d     = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        sum_d[base_s +: NIBBLE_W] = add_s_s;
        carry_d                   = add_co_s;
        if (k_q == K_LAST) begin
          cout_d  = add_co_s;
          // add_s_s[3] is the result MSB written this very cycle
          ovf_d   = (a_q[W-1] == b_eff_msb_s) && (add_s_s[NIBBLE_W-1] != a_q[W-1]);
          k_d     = '0;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moore flags registered from the next state so they align with it
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers with asynchronous clear
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Directed-vector bench with a scoreboard: the stimulus process pushes the
// hand-computed result of every accepted operation; a monitor process samples
// on the falling edge and checks each Done pulse, Busy run length, partial
// Sum filling, Done spacing, and output clearing under Reset.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         Clock;
  logic         Reset;
  logic         Start;
  logic         Sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           gap;   // required cycles since previous Done, 0 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  bit   stim_done;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Monitor / scoreboard: all comparisons happen here
  initial begin
    int   cyc;
    int   busy_run;
    int   since_done;
    exp_t e;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    busy_run   = 0;
    since_done = 0;
    while (!stim_done && cyc < 3000) begin
      @(negedge Clock);
      cyc++;
      since_done++;
      if (Reset) begin
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_sum",  32'(Sum),  32'd0);
        chk("reset_cout", 32'(Cout), 32'd0);
        chk("reset_ovf",  32'(Ovf),  32'd0);
        busy_run   = 0;
        since_done = 0;
      end else begin
        if (Busy) begin
          busy_run++;
          // nibbles not yet processed must still read zero
          chk("partial_sum_upper", 32'(Sum >> (4 * (busy_run - 1))), 32'd0);
          chk("busy_not_done", 32'(Done), 32'd0);
        end
        if (Done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got Done=1 with Sum=0x%0h, expected no Done", Sum);
          end else begin
            e = exp_q.pop_front();
            chk("sum",  32'(Sum),  32'(e.sum));
            chk("cout", 32'(Cout), 32'(e.cout));
            chk("ovf",  32'(Ovf),  32'(e.ovf));
            chk("busy_cycles", 32'(busy_run), 32'(NIBBLES));
            if (e.gap != 0) begin
              chk("done_spacing", 32'(since_done), 32'(e.gap));
            end
          end
          busy_run   = 0;
          since_done = 0;
        end
      end
    end
    if (cyc >= 3000) begin
      checks++;
      errors++;
      $display("FAIL watchdog: got %0d cycles, expected under 3000", cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_results: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic wait_done(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge Clock);
      if (Done) seen = 1'b1;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    @(negedge Clock);
    A = a; B = b; Cin = ci; Sub = sb; Start = 1'b1;
    exp_q.push_back('{es, ec, eo, 0});
    @(negedge Clock);
    Start = 1'b0;
    wait_done(20);
  endtask

  // Stimulus: directed operations with hand-computed results
  initial begin
    int n;
    stim_done = 1'b0;
    Reset = 1'b1; Start = 1'b0; Sub = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;

    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Operand changes and Start re-pulses during RUN must be ignored
    @(negedge Clock);
    A = 16'h1234; B = 16'h1111; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
    exp_q.push_back('{16'h2345, 1'b0, 1'b0, 0});
    @(negedge Clock);
    A = 16'hFFFF; B = 16'hFFFF; Sub = 1'b1; Cin = 1'b1;
    @(negedge Clock);
    Start = 1'b0; A = 16'h0000;
    wait_done(20);

    // Start held high: back-to-back operations every NIBBLES+2 cycles
    @(negedge Clock);
    A = 16'h0003; B = 16'h0004; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
    exp_q.push_back('{16'h0007, 1'b0, 1'b0, 0});
    exp_q.push_back('{16'h0007, 1'b0, 1'b0, NIBBLES + 2});
    exp_q.push_back('{16'h0007, 1'b0, 1'b0, NIBBLES + 2});
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge Clock);
      if (Done) n++;
    end
    Start = 1'b0;
    repeat (3) @(negedge Clock);

    // Reset asserted inside the second RUN cycle abandons the operation
    A = 16'h1234; B = 16'h0001; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    @(posedge Clock);
    #2 Reset = 1'b1;
    @(posedge Clock);
    #2 Reset = 1'b0;
    repeat (2) @(negedge Clock);

    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (5) @(negedge Clock);
    stim_done = 1'b1;
  end

endmodule
